// File: rtl/decode_pkg.sv
// decode_pkg: shared constants for the decode stage.
// One-hot bit indices, MIPS opcode/funct codes and buffer state enum.
package decode_pkg;

    localparam int IDX_ADD     = 0;
    localparam int IDX_ADDU    = 1;
    localparam int IDX_SUB     = 2;
    localparam int IDX_SUBU    = 3;
    localparam int IDX_AND     = 4;
    localparam int IDX_OR      = 5;
    localparam int IDX_XOR     = 6;
    localparam int IDX_NOR     = 7;
    localparam int IDX_SLT     = 8;
    localparam int IDX_SLTU    = 9;
    localparam int IDX_SLL     = 10;
    localparam int IDX_SRL     = 11;
    localparam int IDX_SRA     = 12;
    localparam int IDX_SLLV    = 13;
    localparam int IDX_SRLV    = 14;
    localparam int IDX_SRAV    = 15;
    localparam int IDX_JR      = 16;
    localparam int IDX_ADDI    = 17;
    localparam int IDX_ADDIU   = 18;
    localparam int IDX_ANDI    = 19;
    localparam int IDX_ORI     = 20;
    localparam int IDX_XORI    = 21;
    localparam int IDX_LUI     = 22;
    localparam int IDX_LW      = 23;
    localparam int IDX_SW      = 24;
    localparam int IDX_BEQ     = 25;
    localparam int IDX_BNE     = 26;
    localparam int IDX_SLTI    = 27;
    localparam int IDX_SLTIU   = 28;
    localparam int IDX_J       = 29;
    localparam int IDX_JAL     = 30;
    localparam int IDX_ILLEGAL = 31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } buf_state_t;

endpackage

// File: rtl/decode_onehot.sv
// decode_onehot: combinational instruction word to one-hot class vector.
// Ports: instr[31:0] in, onehot[31:0] out (bit 31 = illegal).
module decode_onehot
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] onehot
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_fields;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Register/immediate fields are decoded downstream from instr_out.
    assign unused_fields = ^instr[25:6];

    always_comb begin
        onehot = '0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  onehot[IDX_ADD]  = 1'b1;
                FN_ADDU: onehot[IDX_ADDU] = 1'b1;
                FN_SUB:  onehot[IDX_SUB]  = 1'b1;
                FN_SUBU: onehot[IDX_SUBU] = 1'b1;
                FN_AND:  onehot[IDX_AND]  = 1'b1;
                FN_OR:   onehot[IDX_OR]   = 1'b1;
                FN_XOR:  onehot[IDX_XOR]  = 1'b1;
                FN_NOR:  onehot[IDX_NOR]  = 1'b1;
                FN_SLT:  onehot[IDX_SLT]  = 1'b1;
                FN_SLTU: onehot[IDX_SLTU] = 1'b1;
                FN_SLL:  onehot[IDX_SLL]  = 1'b1;
                FN_SRL:  onehot[IDX_SRL]  = 1'b1;
                FN_SRA:  onehot[IDX_SRA]  = 1'b1;
                FN_SLLV: onehot[IDX_SLLV] = 1'b1;
                FN_SRLV: onehot[IDX_SRLV] = 1'b1;
                FN_SRAV: onehot[IDX_SRAV] = 1'b1;
                FN_JR:   onehot[IDX_JR]   = 1'b1;
                default: onehot[IDX_ILLEGAL] = 1'b1;
            endcase
        end else begin
            case (op)
                OP_ADDI:  onehot[IDX_ADDI]  = 1'b1;
                OP_ADDIU: onehot[IDX_ADDIU] = 1'b1;
                OP_ANDI:  onehot[IDX_ANDI]  = 1'b1;
                OP_ORI:   onehot[IDX_ORI]   = 1'b1;
                OP_XORI:  onehot[IDX_XORI]  = 1'b1;
                OP_LUI:   onehot[IDX_LUI]   = 1'b1;
                OP_LW:    onehot[IDX_LW]    = 1'b1;
                OP_SW:    onehot[IDX_SW]    = 1'b1;
                OP_BEQ:   onehot[IDX_BEQ]   = 1'b1;
                OP_BNE:   onehot[IDX_BNE]   = 1'b1;
                OP_SLTI:  onehot[IDX_SLTI]  = 1'b1;
                OP_SLTIU: onehot[IDX_SLTIU] = 1'b1;
                OP_J:     onehot[IDX_J]     = 1'b1;
                OP_JAL:   onehot[IDX_JAL]   = 1'b1;
                default:  onehot[IDX_ILLEGAL] = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with 2-entry skid buffer and flush.
// Ports: clk, rst (sync high); in: instr_in/pc_in/in_valid -> in_ready;
// out: decoded_instr/instr_out/pc_out/out_valid <- out_ready; flush.
// Optional illegal_cnt[15:0] when DECODE_ILLEGAL_CNT_EN is defined.
module decode_stage
    import decode_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     decoded_instr,
    output logic [31:0]     instr_out,
    output logic [PC_W-1:0] pc_out,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]     illegal_cnt
`endif
);

    buf_state_t      state;
    buf_state_t      state_nxt;
    logic            in_fire;
    logic            out_fire;
    logic            load_head_in;
    logic            load_head_skid;
    logic            load_skid;
    logic [31:0]     dec;
    logic [31:0]     skid_onehot;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    decode_onehot u_dec (
        .instr  (instr_in),
        .onehot (dec)
    );

    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_head_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            out_valid     <= 1'b0;
            in_ready      <= 1'b1;
            decoded_instr <= '0;
            instr_out     <= '0;
            pc_out        <= '0;
            skid_onehot   <= '0;
            skid_instr    <= '0;
            skid_pc       <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != TWO);
            if (load_head_in) begin
                decoded_instr <= dec;
                instr_out     <= instr_in;
                pc_out        <= pc_in;
            end else if (load_head_skid) begin
                decoded_instr <= skid_onehot;
                instr_out     <= skid_instr;
                pc_out        <= skid_pc;
            end
            if (load_skid) begin
                skid_onehot <= dec;
                skid_instr  <= instr_in;
                skid_pc     <= pc_in;
            end
        end
    end

`ifdef DECODE_ILLEGAL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (in_fire && !flush && dec[IDX_ILLEGAL]
                     && illegal_cnt != 16'hFFFF) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage for the 31-instruction MIPS core. It accepts raw 32-bit instruction words and their PC from fetch over a valid/ready handshake, and produces the one-hot `decoded_instr[31:0]` vector that the control unit consumes. A 2-entry skid buffer gives full throughput with a registered `in_ready`, and a `flush` input squashes in-flight words on taken branches and jumps.

## Interface
Parameters:
- `PC_W`, 32, width of the PC carried alongside each instruction

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `instr_in`  in  32  raw instruction word from fetch
- `pc_in`  in  PC_W  PC of `instr_in`
- `in_valid`  in  1  fetch presents a word
- `in_ready`  out  1  stage can accept; registered
- `decoded_instr`  out  32  one-hot decode of the head entry
- `instr_out`  out  32  raw head instruction, used for rs/rt/rd/shamt/imm fields
- `pc_out`  out  PC_W  head PC
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream consumes the head
- `flush`  in  1  squash all held and incoming words
- `illegal_cnt`  out  16  illegal-instruction count; present only under `DECODE_ILLEGAL_CNT_EN`

## Operation
- One-hot index map:
  - R-type funct: 0 add 0x20; 1 addu 0x21; 2 sub 0x22; 3 subu 0x23; 4 and 0x24; 5 or 0x25; 6 xor 0x26; 7 nor 0x27; 8 slt 0x2A; 9 sltu 0x2B; 10 sll 0x00; 11 srl 0x02; 12 sra 0x03; 13 sllv 0x04; 14 srlv 0x06; 15 srav 0x07; 16 jr 0x08.
  - Opcodes: 17 addi 0x08; 18 addiu 0x09; 19 andi 0x0C; 20 ori 0x0D; 21 xori 0x0E; 22 lui 0x0F; 23 lw 0x23; 24 sw 0x2B; 25 beq 0x04; 26 bne 0x05; 27 slti 0x0A; 28 sltiu 0x0B; 29 j 0x02; 30 jal 0x03.
  - Bit 31 is illegal: any opcode/funct not listed above.
- R-type means opcode 0x00, decoded on funct[5:0]. Other fields are not checked; 0x00000000 decodes as sll (bit 10).
- Exactly one bit of `decoded_instr` is set whenever `out_valid` = 1.
- Decode is combinational on `instr_in` and the result is registered with the word. Outputs come only from flops.
- Buffer states:
  - EMPTY: no entry held.
  - ONE: head only.
  - TWO: head and skid.
- Transitions, with in = `in_valid & in_ready` and out = `out_valid & out_ready`:
  - EMPTY + in → ONE.
  - ONE + in, no out → TWO.
  - ONE + out, no in → EMPTY.
  - ONE + in + out → ONE, loaded with the new word.
  - TWO + out → ONE; skid moves to head.
  - TWO never accepts input.
- `in_ready` = 1 in EMPTY and ONE, 0 in TWO. It is registered from the next state.
- `flush` has priority over every other event. The next state is EMPTY and `out_valid` drops the next cycle. A handshake in the flush cycle completes but its word is discarded. A head consumed in the flush cycle counts as consumed.
- Reset: state EMPTY, `out_valid` 0, `in_ready` 1, `decoded_instr`/`instr_out`/`pc_out` 0, `illegal_cnt` 0.

## Timing
- Latency: a word accepted at edge N is at the head with `out_valid` = 1 after edge N. If the buffer holds an older word, the new word reaches the head after that word is consumed.
- Throughput: 1 word/cycle when `out_ready` is held at 1.
- `in_ready` deasserts the cycle after the buffer fills (TWO) and reasserts the cycle after a drain.
- The head's data is stable while `out_valid` = 1 and `out_ready` = 0.
- Reset mid-operation drops both entries on the same edge.

## Configuration
- `DECODE_ILLEGAL_CNT_EN` defined:
  - `illegal_cnt` exists.
  - It increments by 1 on each accepted, non-flushed word with bit 31 set.
  - It saturates at 0xFFFF and is cleared only by `rst`.
- Undefined: the port and counter are absent; decode is unchanged.

## Structure
- `decode_pkg`:
  - one-hot index constants (`IDX_ADD` … `IDX_JAL`, `IDX_ILLEGAL`);
  - opcode and funct localparams;
  - state enum {EMPTY, ONE, TWO}.
- Sub-module `decode_onehot`: purely combinational, `instr[31:0]` → `onehot[31:0]`. It is instantiated once on the input path.

## Test plan
- Sweep all 31 legal encodings singly with `out_ready` = 1, plus opcode 0x3F → `decoded_instr` = 1<<idx, one cycle after accept. 0x3F sets bit 31.
- Hold `out_ready` = 0 while streaming 3 words → 2 accepted and `in_ready` = 0 from the cycle after the 2nd. Raise `out_ready` → words exit in order, none lost.
- Back-to-back stream of 100 words with `out_ready` = 1 → 100 outputs in 101 cycles, `in_ready` constant 1.
- Buffer in TWO, assert `flush` with `in_valid` = 1 → `out_valid` = 0 next cycle, state EMPTY, `in_ready` = 1, the flushed input never appears.
- Assert `rst` with the buffer full → outputs at reset values next cycle, `in_ready` = 1.
- With `DECODE_ILLEGAL_CNT_EN`, feed 3 illegal words (one flushed) → `illegal_cnt` = 2. Force the counter to 0xFFFF → it stays at 0xFFFF.
